// File: rtl/fpu_writeback_if.sv
// fpu_writeback_if
// Result-path handshake bundle between the FPU execute pipeline, the
// writeback buffer and the downstream result consumer.
//   in_valid / in_ready / in_result / in_operator   : execute -> buffer
//   out_valid / out_ready / out_result / out_operator / out_class : buffer -> consumer
// Modports:
//   slave  : the writeback buffer's view (accepts in_*, drives out_*)
//   master : the surrounding logic's view (drives in_*, takes out_*)
interface fpu_writeback_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [1:0]  in_operator;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [1:0]  out_operator;
  logic [3:0]  out_class;

  modport slave (
    input  in_valid, in_result, in_operator, out_ready,
    output in_ready, out_valid, out_result, out_operator, out_class
  );

  modport master (
    output in_valid, in_result, in_operator, out_ready,
    input  in_ready, out_valid, out_result, out_operator, out_class
  );
endinterface

// File: rtl/fpu_writeback.sv
// fpu_writeback
// Accepts one completed single-precision result per cycle, classifies it
// as {nan, inf, zero, denorm}, and queues {result, operator, class} in a
// DEPTH-entry circular buffer for a valid/ready consumer. Keeps sticky
// class flags and a sticky drop flag for results offered while full.
// Ports:
//   clk, rst_n    : clock (rising edge), async active-low reset
//   wb (slave)    : in_* producer side and out_* consumer side handshake
//   flags_clr     : synchronous clear of sticky_flags and drop_err
//   fill_level    : current entry count
//   sticky_flags  : OR of class bits of all accepted results since clear
//   drop_err      : sticky, a result was offered while in_ready was low
module fpu_writeback #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  fpu_writeback_if.slave wb,
  input  logic          flags_clr,
  output logic [CW-1:0] fill_level,
  output logic [3:0]    sticky_flags,
  output logic          drop_err
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_result   [DEPTH];
  logic [1:0]    mem_operator [DEPTH];
  logic [3:0]    mem_class    [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] count;

  logic [7:0]  in_exp;
  logic [22:0] in_man;
  logic [3:0]  in_class;
  logic        push;
  logic        pop;
  logic        drop;

  // Classification, bit order {nan, inf, zero, denorm}; sign is ignored so
  // both +0 and -0 classify as zero.
  always_comb begin
    in_exp   = wb.in_result[30:23];
    in_man   = wb.in_result[22:0];
    in_class = 4'b0000;
    if (in_exp == 8'hFF) begin
      in_class = (in_man != 23'd0) ? 4'b1000 : 4'b0100;
    end else if (in_exp == 8'h00) begin
      in_class = (in_man == 23'd0) ? 4'b0010 : 4'b0001;
    end
  end

  // Readiness depends only on count, so a full buffer never accepts even
  // when the consumer pops in the same cycle.
  assign wb.in_ready  = (count < CW'(DEPTH));
  assign wb.out_valid = (count != '0);
  assign fill_level   = count;

  assign push = wb.in_valid & wb.in_ready;
  assign pop  = wb.out_valid & wb.out_ready;
  assign drop = wb.in_valid & ~wb.in_ready;

  // Head entry comes straight from storage; no path from in_* inputs.
  assign wb.out_result   = mem_result[rp];
  assign wb.out_operator = mem_operator[rp];
  assign wb.out_class    = mem_class[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_result[i]   <= '0;
        mem_operator[i] <= '0;
        mem_class[i]    <= '0;
      end
    end else begin
      if (push) begin
        mem_result[wp]   <= wb.in_result;
        mem_operator[wp] <= wb.in_operator;
        mem_class[wp]    <= in_class;
        wp               <= wp + AW'(1);
      end
      if (pop) begin
        rp <= rp + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A clear coinciding with a push or drop leaves only the new event's bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= 4'b0000;
      drop_err     <= 1'b0;
    end else begin
      if (flags_clr) begin
        sticky_flags <= push ? in_class : 4'b0000;
      end else if (push) begin
        sticky_flags <= sticky_flags | in_class;
      end

      if (drop) begin
        drop_err <= 1'b1;
      end else if (flags_clr) begin
        drop_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_writeback.sv
// tb_fpu_writeback
// Directed-vector bench for fpu_writeback with hand-computed expectations.
module tb_fpu_writeback;

  logic       clk;
  logic       rst_n;
  logic       flags_clr;
  logic [2:0] fill_level;
  logic [3:0] sticky_flags;
  logic       drop_err;

  int checks;
  int errors;

  fpu_writeback_if wb ();

  fpu_writeback #(.DEPTH(4), .CW(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb           (wb.slave),
    .flags_clr    (flags_clr),
    .fill_level   (fill_level),
    .sticky_flags (sticky_flags),
    .drop_err     (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] fill_vals [4];
  logic [3:0]  fill_cls  [4];

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    flags_clr    = 1'b0;
    wb.in_valid  = 1'b0;
    wb.in_result = 32'h0;
    wb.in_operator = 2'b00;
    wb.out_ready = 1'b0;

    fill_vals[0] = 32'h7F800000; fill_cls[0] = 4'b0100;
    fill_vals[1] = 32'h7FC00000; fill_cls[1] = 4'b1000;
    fill_vals[2] = 32'h00000000; fill_cls[2] = 4'b0010;
    fill_vals[3] = 32'h00000001; fill_cls[3] = 4'b0001;

    #12;
    check("rst_in_ready",  32'(wb.in_ready), 32'd1);
    check("rst_out_valid", 32'(wb.out_valid), 32'd0);
    check("rst_fill",      32'(fill_level), 32'd0);
    check("rst_out_result", wb.out_result, 32'h0);
    check("rst_sticky",    32'(sticky_flags), 32'd0);
    check("rst_drop",      32'(drop_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // single push of 1.0
    wb.in_valid = 1'b1; wb.in_result = 32'h3F800000; wb.in_operator = 2'b01;
    tick();
    wb.in_valid = 1'b0;
    check("p1_out_valid", 32'(wb.out_valid), 32'd1);
    check("p1_out_result", wb.out_result, 32'h3F800000);
    check("p1_out_op",    32'(wb.out_operator), 32'd1);
    check("p1_out_class", 32'(wb.out_class), 32'd0);
    check("p1_fill",      32'(fill_level), 32'd1);
    check("p1_sticky",    32'(sticky_flags), 32'd0);

    // pop it to empty the buffer
    wb.out_ready = 1'b1;
    tick();
    wb.out_ready = 1'b0;
    check("pop1_fill",  32'(fill_level), 32'd0);
    check("pop1_valid", 32'(wb.out_valid), 32'd0);

    // fill with inf, nan, zero, denorm
    for (int i = 0; i < 4; i++) begin
      wb.in_valid = 1'b1; wb.in_result = fill_vals[i]; wb.in_operator = 2'(i);
      tick();
    end
    wb.in_valid = 1'b0;
    check("full_fill",     32'(fill_level), 32'd4);
    check("full_in_ready", 32'(wb.in_ready), 32'd0);
    check("full_sticky",   32'(sticky_flags), 32'hF);
    check("full_drop",     32'(drop_err), 32'd0);
    check("full_head_cls", 32'(wb.out_class), 32'(fill_cls[0]));

    // pop while full, concurrent offer must be dropped
    wb.out_ready = 1'b1; wb.in_valid = 1'b1; wb.in_result = 32'h40000000;
    tick();
    wb.in_valid = 1'b0;
    check("drop_err",  32'(drop_err), 32'd1);
    check("drop_fill", 32'(fill_level), 32'd3);

    // drain remaining nan, zero, denorm in order
    for (int i = 1; i < 4; i++) begin
      check($sformatf("drain%0d_result", i), wb.out_result, fill_vals[i]);
      check($sformatf("drain%0d_class", i), 32'(wb.out_class), 32'(fill_cls[i]));
      check($sformatf("drain%0d_op", i), 32'(wb.out_operator), 32'(i));
      tick();
    end
    wb.out_ready = 1'b0;
    check("drain_empty", 32'(wb.out_valid), 32'd0);
    check("drain_fill",  32'(fill_level), 32'd0);

    // clear flags
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    check("clr_sticky", 32'(sticky_flags), 32'd0);
    check("clr_drop",   32'(drop_err), 32'd0);

    // streaming 1..10, one-cycle latency, fill stays 1
    wb.in_valid = 1'b1; wb.out_ready = 1'b1; wb.in_operator = 2'b10;
    for (int i = 1; i <= 10; i++) begin
      wb.in_result = 32'(i);
      tick();
      check($sformatf("stream%0d_result", i), wb.out_result, 32'(i));
      check($sformatf("stream%0d_fill", i), 32'(fill_level), 32'd1);
    end
    wb.in_valid = 1'b0;
    tick();
    wb.out_ready = 1'b0;
    check("stream_end_fill", 32'(fill_level), 32'd0);
    check("stream_drop",     32'(drop_err), 32'd0);
    check("stream_sticky",   32'(sticky_flags), 32'b0001);

    // clear coinciding with inf push
    flags_clr = 1'b1; wb.in_valid = 1'b1; wb.in_result = 32'h7F800000;
    tick();
    flags_clr = 1'b0;
    check("clrpush_sticky", 32'(sticky_flags), 32'b0100);
    check("clrpush_drop",   32'(drop_err), 32'd0);

    // two more entries -> 3 buffered, then async reset between edges
    wb.in_result = 32'h3F800000;
    tick();
    wb.in_result = 32'hBF800000;
    tick();
    wb.in_valid = 1'b0;
    check("pre_rst_fill", 32'(fill_level), 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(wb.out_valid), 32'd0);
    check("arst_fill",      32'(fill_level), 32'd0);
    check("arst_in_ready",  32'(wb.in_ready), 32'd1);
    check("arst_sticky",    32'(sticky_flags), 32'd0);
    check("arst_out_result", wb.out_result, 32'h0);
    #2;
    rst_n = 1'b1;

    // behaves as from empty
    tick();
    wb.in_valid = 1'b1; wb.in_result = 32'h80000000; wb.in_operator = 2'b11;
    tick();
    wb.in_valid = 1'b0;
    check("post_rst_fill",   32'(fill_level), 32'd1);
    check("post_rst_result", wb.out_result, 32'h80000000);
    check("post_rst_class",  32'(wb.out_class), 32'b0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
